// File: rtl/ascon_io_pkg.sv
// Shared definitions for the ASCON serial I/O front end: controller state
// encoding and the small parameter helpers used to size beat counters.
package ascon_io_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_LOADED = 3'd2,
    ST_RUN    = 3'd3,
    ST_UNLOAD = 3'd4
  } io_state_e;

  // Number of serial beats needed to move a field of 'bits' bits over a
  // W-bit lane (all widths are exact multiples of the lane width).
  function automatic int beat_count(input int bits, input int w);
    return bits / w;
  endfunction

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter width able to hold values 0..n-1 (never less than one bit).
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ascon_serial_io_if.sv
// Serial side of the ASCON I/O block: input beat bus carrying the shared
// key/nonce/AD/ciphertext lanes plus randomness, and the output beat bus
// returning plaintext and tag. 'master' is the serial source/sink, 'slave'
// is the I/O block.
interface ascon_serial_io_if #(
  parameter int SH  = 3,
  parameter int W   = 1,
  parameter int RCH = 7
) ();

  logic              si_valid;
  logic              si_ready;
  logic [SH*W-1:0]   key_si;
  logic [SH*W-1:0]   nonce_si;
  logic [SH*W-1:0]   ad_si;
  logic [SH*W-1:0]   ct_si;
  logic [RCH*W-1:0]  rnd_si;

  logic              so_valid;
  logic              so_ready;
  logic [W-1:0]      pt_so;
  logic [W-1:0]      tag_so;

  modport master (
    output si_valid, key_si, nonce_si, ad_si, ct_si, rnd_si, so_ready,
    input  si_ready, so_valid, pt_so, tag_so
  );

  modport slave (
    input  si_valid, key_si, nonce_si, ad_si, ct_si, rnd_si, so_ready,
    output si_ready, so_valid, pt_so, tag_so
  );

endinterface

// File: rtl/ascon_shift_deser.sv
// Serial-to-parallel shift register for one field share or randomness
// channel. Each enabled beat shifts the register left by one lane and
// inserts the new lane at the LSB end, so the first beat ends up in the MSBs.
// Shifting stops once LIMIT beats have been taken, which lets a short field
// sit still while longer fields keep loading.
module ascon_shift_deser
  import ascon_io_pkg::*;
#(
  parameter int N     = 128,
  parameter int W     = 1,
  parameter int LIMIT = beat_count(N, W),
  parameter int CW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic [CW-1:0] idx_i,
  input  logic [W-1:0]  lane_i,
  output logic [N-1:0]  data_o
);

  logic [N-1:0] data_q;
  logic [N-1:0] data_d;
  logic         shift_en;

  // Only beats whose index is still inside this field's length move data.
  assign shift_en = en_i && (int'(idx_i) < LIMIT);

  generate
    if (N == W) begin : g_whole
      assign data_d = lane_i;
    end else begin : g_shift
      assign data_d = {data_q[N-W-1:0], lane_i};
    end
  endgenerate

  // Field register: cleared by reset, otherwise holds until the next load.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else if (shift_en) begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/ascon_serial_io.sv
// Serial I/O wrapper for a masked ASCON decryption core. Shared key, nonce,
// associated data, ciphertext and randomness arrive W bits per lane per
// beat and are deserialised into parallel registers for the core. After a
// start request the core is kicked with a one-cycle pulse; its plaintext and
// tag are latched on completion and streamed back out LSB-first.
module ascon_serial_io
  import ascon_io_pkg::*;
#(
  parameter int K   = 128,
  parameter int L   = 80,
  parameter int Y   = 80,
  parameter int SH  = 3,
  parameter int W   = 1,
  parameter int RCH = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  ascon_serial_io_if.slave     sio,
  input  logic                 start,
  output logic                 core_start,
  output logic [SH*K-1:0]      core_key,
  output logic [SH*128-1:0]    core_nonce,
  output logic [SH*L-1:0]      core_ad,
  output logic [SH*Y-1:0]      core_ct,
  output logic [RCH*64-1:0]    core_rnd,
  input  logic                 core_done,
  input  logic [Y-1:0]         core_pt,
  input  logic [127:0]         core_tag,
  output logic                 busy
);

  // Input phase lasts as long as the longest field; output phase as long as
  // the longer of plaintext and tag.
  localparam int MAXB = max_of(max_of(max_of(K, 128), max_of(L, Y)), 64) / W;
  localparam int OUTB = max_of(Y, 128) / W;
  localparam int YB   = beat_count(Y, W);
  localparam int TB   = beat_count(128, W);
  localparam int CW   = idx_width(MAXB + 1);
  localparam int OCW  = idx_width(OUTB);
  localparam logic [CW-1:0]  MAXB_LAST = CW'(MAXB - 1);
  localparam logic [OCW-1:0] OUTB_LAST = OCW'(OUTB - 1);

  generate
    if ((K % W) != 0 || (128 % W) != 0 || (L % W) != 0 ||
        (Y % W) != 0 || (64 % W) != 0) begin : g_bad_lane_width
      $error("ascon_serial_io: K, 128, L, Y and 64 must be multiples of W");
    end
  endgenerate

  io_state_e      state_q;
  logic [CW-1:0]  in_cnt_q;
  logic [OCW-1:0] out_cnt_q;
  logic [Y-1:0]   pt_lat_q;
  logic [127:0]   tag_lat_q;
  logic           si_ready_q;
  logic           busy_q;
  logic           core_start_q;
  logic           so_valid_q;
  logic [W-1:0]   pt_so_q;
  logic [W-1:0]   tag_so_q;

  logic           beat_acc;
  logic [OCW-1:0] out_nxt_d;
  logic [Y-1:0]   pt_shift_d;
  logic [127:0]   tag_shift_d;
  logic [W-1:0]   pt_beat_d;
  logic [W-1:0]   tag_beat_d;

  assign beat_acc = sio.si_valid & si_ready_q;

  // Deserialisers: one per share of each secret field, one per randomness
  // channel. All share the accepted-beat strobe and the global beat index.
  genvar gi;
  generate
    for (gi = 0; gi < SH; gi++) begin : g_share
      ascon_shift_deser #(.N(K), .W(W), .LIMIT(beat_count(K, W)), .CW(CW)) u_key (
        .clk(clk), .rst(rst), .en_i(beat_acc), .idx_i(in_cnt_q),
        .lane_i(sio.key_si[gi*W +: W]), .data_o(core_key[gi*K +: K])
      );
      ascon_shift_deser #(.N(128), .W(W), .LIMIT(beat_count(128, W)), .CW(CW)) u_nonce (
        .clk(clk), .rst(rst), .en_i(beat_acc), .idx_i(in_cnt_q),
        .lane_i(sio.nonce_si[gi*W +: W]), .data_o(core_nonce[gi*128 +: 128])
      );
      ascon_shift_deser #(.N(L), .W(W), .LIMIT(beat_count(L, W)), .CW(CW)) u_ad (
        .clk(clk), .rst(rst), .en_i(beat_acc), .idx_i(in_cnt_q),
        .lane_i(sio.ad_si[gi*W +: W]), .data_o(core_ad[gi*L +: L])
      );
      ascon_shift_deser #(.N(Y), .W(W), .LIMIT(beat_count(Y, W)), .CW(CW)) u_ct (
        .clk(clk), .rst(rst), .en_i(beat_acc), .idx_i(in_cnt_q),
        .lane_i(sio.ct_si[gi*W +: W]), .data_o(core_ct[gi*Y +: Y])
      );
    end

    for (gi = 0; gi < RCH; gi++) begin : g_rnd
      ascon_shift_deser #(.N(64), .W(W), .LIMIT(beat_count(64, W)), .CW(CW)) u_rnd (
        .clk(clk), .rst(rst), .en_i(beat_acc), .idx_i(in_cnt_q),
        .lane_i(sio.rnd_si[gi*W +: W]), .data_o(core_rnd[gi*64 +: 64])
      );
    end
  endgenerate

  // Next output beat: slice of the latched results at the following index,
  // padded with zeros once the shorter result has been fully sent.
  always_comb begin
    out_nxt_d   = out_cnt_q + 1'b1;
    pt_shift_d  = pt_lat_q >> (int'(out_nxt_d) * W);
    tag_shift_d = tag_lat_q >> (int'(out_nxt_d) * W);
    pt_beat_d   = (int'(out_nxt_d) < YB) ? pt_shift_d[W-1:0] : '0;
    tag_beat_d  = (int'(out_nxt_d) < TB) ? tag_shift_d[W-1:0] : '0;
  end

  // Controller: sequences load, core run and unload; every handshake and
  // status output is registered and updated together with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      pt_lat_q     <= '0;
      tag_lat_q    <= '0;
      si_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      core_start_q <= 1'b0;
      so_valid_q   <= 1'b0;
      pt_so_q      <= '0;
      tag_so_q     <= '0;
    end else begin
      core_start_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_LOAD: begin
          if (beat_acc) begin
            in_cnt_q <= in_cnt_q + 1'b1;
            busy_q   <= 1'b1;
            if (in_cnt_q == MAXB_LAST) begin
              state_q    <= ST_LOADED;
              si_ready_q <= 1'b0;
            end else begin
              state_q <= ST_LOAD;
            end
          end
        end
        ST_LOADED: begin
          if (start) begin
            state_q      <= ST_RUN;
            core_start_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (core_done) begin
            state_q    <= ST_UNLOAD;
            pt_lat_q   <= core_pt;
            tag_lat_q  <= core_tag;
            out_cnt_q  <= '0;
            so_valid_q <= 1'b1;
            pt_so_q    <= core_pt[W-1:0];
            tag_so_q   <= core_tag[W-1:0];
          end
        end
        ST_UNLOAD: begin
          if (sio.so_ready) begin
            if (out_cnt_q == OUTB_LAST) begin
              state_q    <= ST_IDLE;
              in_cnt_q   <= '0;
              out_cnt_q  <= '0;
              si_ready_q <= 1'b1;
              busy_q     <= 1'b0;
              so_valid_q <= 1'b0;
              pt_so_q    <= '0;
              tag_so_q   <= '0;
            end else begin
              out_cnt_q <= out_nxt_d;
              pt_so_q   <= pt_beat_d;
              tag_so_q  <= tag_beat_d;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign sio.si_ready = si_ready_q;
  assign sio.so_valid = so_valid_q;
  assign sio.pt_so    = pt_so_q;
  assign sio.tag_so   = tag_so_q;
  assign core_start   = core_start_q;
  assign busy         = busy_q;

endmodule
